// File: rtl/fabric_spi_transmitter.sv
// ---------------------------------------------------------------------------
// fabric_spi_transmitter
//
// SPI host, mode 0 (CPOL=0, CPHA=0), MSB first. Serialises WORD_WIDTH-bit
// words taken from a valid/ready stream onto sclk_o/cs_no/mosi_o. cs_no is
// held low across every word of a frame and released after the word that
// carried bitstream_last_i. miso_i is shifted in concurrently and every
// completed word is presented on rx_data_o with a one-cycle rx_valid_o pulse.
//
// Parameters
//   CLK_DIV     SCLK half-period in clk_i cycles (>= 1)
//   WORD_WIDTH  bits per word
//
// Ports
//   clk_i              system clock
//   rst_i              synchronous, active-high reset
//   bitstream_data_i   word to transmit
//   bitstream_last_i   word closes the frame (sampled on transfer only)
//   bitstream_valid_i  word available
//   bitstream_ready_o  word accepted this cycle when valid is also high
//   rx_data_o          last word captured from miso_i
//   rx_valid_o         one-cycle pulse, rx_data_o just updated
//   busy_o             transmitter not idle
//   sclk_o             SPI clock, idles low
//   cs_no              chip select, active low
//   mosi_o             serial data out
//   miso_i             serial data in
//
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module fabric_spi_transmitter #(
    parameter int CLK_DIV    = 2,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [WORD_WIDTH-1:0] bitstream_data_i,
    input  logic                  bitstream_last_i,
    input  logic                  bitstream_valid_i,
    output logic                  bitstream_ready_o,
    output logic [WORD_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    output logic                  busy_o,
    output logic                  sclk_o,
    output logic                  cs_no,
    output logic                  mosi_o,
    input  logic                  miso_i
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(WORD_WIDTH + 1);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WORD_WIDTH);
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_WORD_END,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t                  state_q,    state_d;
    logic [DIV_W-1:0]        div_q,      div_d;
    logic [BIT_W-1:0]        bit_q,      bit_d;
    logic [WORD_WIDTH-1:0]   tx_shift_q, tx_shift_d;
    logic [WORD_WIDTH-1:0]   rx_shift_q, rx_shift_d;
    logic                    last_q,     last_d;
    logic                    sclk_q,     sclk_d;
    logic                    cs_n_q,     cs_n_d;
    logic                    mosi_q,     mosi_d;
    logic                    ready_q,    ready_d;
    logic                    rx_valid_q, rx_valid_d;
    logic [WORD_WIDTH-1:0]   rx_data_q,  rx_data_d;
    logic                    busy_q,     busy_d;

    logic div_done;
    logic take;
    logic load;

    assign div_done = (div_q == DIV_LAST);
    assign take     = bitstream_valid_i && ready_q;

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        last_d     = last_q;
        sclk_d     = sclk_q;
        cs_n_d     = cs_n_q;
        mosi_d     = mosi_q;
        ready_d    = ready_q;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        load       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                load = take;
            end

            // sclk low for CLK_DIV cycles with the MSB already on mosi.
            ST_SETUP: begin
                if (div_done) begin
                    div_d      = '0;
                    sclk_d     = 1'b1;
                    rx_shift_d = {rx_shift_q[WORD_WIDTH-2:0], miso_i};
                    bit_d      = bit_q + BIT_ONE;
                    state_d    = ST_SHIFT;
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end

            // bit_q counts high phases already started; it reaches
            // WORD_WIDTH during the last one, so the end of that high phase
            // closes the word instead of shifting out another bit.
            ST_SHIFT: begin
                if (div_done) begin
                    div_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            rx_valid_d = 1'b1;
                            rx_data_d  = rx_shift_q;
                            ready_d    = ~last_q;
                            state_d    = ST_WORD_END;
                        end else begin
                            mosi_d     = tx_shift_q[WORD_WIDTH-2];
                            tx_shift_d = tx_shift_q << 1;
                        end
                    end else begin
                        sclk_d     = 1'b1;
                        rx_shift_d = {rx_shift_q[WORD_WIDTH-2:0], miso_i};
                        bit_d      = bit_q + BIT_ONE;
                    end
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end

            // For a frame-closing word this cycle already counts as the first
            // cycle of the cs hold time, so cs_no rises exactly CLK_DIV cycles
            // after the final sclk fall (immediately here when CLK_DIV is 1).
            ST_WORD_END: begin
                if (last_q) begin
                    if (div_done) begin
                        div_d   = '0;
                        cs_n_d  = 1'b1;
                        state_d = ST_GAP;
                    end else begin
                        div_d   = div_q + DIV_ONE;
                        state_d = ST_HOLD;
                    end
                end else begin
                    load = take;
                end
            end

            ST_HOLD: begin
                if (div_done) begin
                    div_d   = '0;
                    cs_n_d  = 1'b1;
                    state_d = ST_GAP;
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end

            ST_GAP: begin
                if (div_done) begin
                    div_d   = '0;
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Word load is shared by IDLE and a mid-frame WORD_END. Counters
        // restart here, so the bit counter never wraps.
        if (load) begin
            tx_shift_d = bitstream_data_i;
            last_d     = bitstream_last_i;
            cs_n_d     = 1'b0;
            mosi_d     = bitstream_data_i[WORD_WIDTH-1];
            ready_d    = 1'b0;
            div_d      = '0;
            bit_d      = '0;
            state_d    = ST_SETUP;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            last_q     <= 1'b0;
            sclk_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            ready_q    <= 1'b1;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            last_q     <= last_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            mosi_q     <= mosi_d;
            ready_q    <= ready_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            busy_q     <= busy_d;
        end
    end

    assign bitstream_ready_o = ready_q;
    assign rx_data_o         = rx_data_q;
    assign rx_valid_o        = rx_valid_q;
    assign busy_o            = busy_q;
    assign sclk_o            = sclk_q;
    assign cs_no             = cs_n_q;
    assign mosi_o            = mosi_q;

endmodule

// File: tb/tb_fabric_spi_transmitter.sv
// ---------------------------------------------------------------------------
// tb_fabric_spi_transmitter
//
// Two transmitters: u0 with CLK_DIV=2 (miso looped back from mosi) and u1 with
// CLK_DIV=1 (miso = ~mosi). A bus monitor decodes mosi at sclk rising edges
// the way a receiving SPI device would, and records edge timing, so the
// directed tests compare against hand-computed words and cycle numbers.
// ---------------------------------------------------------------------------
module tb_fabric_spi_transmitter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data    [2];
    logic [31:0] rx_data [2];
    logic [1:0]  valid, last, ready, rx_valid, busy, sclk, cs_n, mosi, miso;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign miso[0] = mosi[0];
    assign miso[1] = ~mosi[1];

    fabric_spi_transmitter #(.CLK_DIV(2), .WORD_WIDTH(32)) u0 (
        .clk_i(clk), .rst_i(rst),
        .bitstream_data_i(data[0]), .bitstream_last_i(last[0]),
        .bitstream_valid_i(valid[0]), .bitstream_ready_o(ready[0]),
        .rx_data_o(rx_data[0]), .rx_valid_o(rx_valid[0]), .busy_o(busy[0]),
        .sclk_o(sclk[0]), .cs_no(cs_n[0]), .mosi_o(mosi[0]), .miso_i(miso[0])
    );

    fabric_spi_transmitter #(.CLK_DIV(1), .WORD_WIDTH(32)) u1 (
        .clk_i(clk), .rst_i(rst),
        .bitstream_data_i(data[1]), .bitstream_last_i(last[1]),
        .bitstream_valid_i(valid[1]), .bitstream_ready_o(ready[1]),
        .rx_data_o(rx_data[1]), .rx_valid_o(rx_valid[1]), .busy_o(busy[1]),
        .sclk_o(sclk[1]), .cs_no(cs_n[1]), .mosi_o(mosi[1]), .miso_i(miso[1])
    );

    // ---------------- bus monitor ----------------
    logic [1:0]  p_sclk = 2'b00, p_cs_n = 2'b11, p_mosi = 2'b00, p_busy = 2'b00;
    int          rises [2], cs_falls [2], cs_rises [2], rx_pulses [2];
    int          cs_rise_cyc [2], sclk_fall_cyc [2], busy_fall_cyc [2];
    int          prev_rise [2], bad_period [2], mosi_bad [2], rise_nocs [2];
    int          mon_bits [2], mon_words [2];
    logic [31:0] mon_shift [2];
    logic [31:0] mon_word [2][8];
    int          word_first_rise [2][8];

    function automatic int half_period(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!cs_n[k] && p_cs_n[k]) begin
                cs_falls[k]  <= cs_falls[k] + 1;
                rises[k]     <= 0;
                mon_bits[k]  <= 0;
                mon_words[k] <= 0;
            end
            if (cs_n[k] && !p_cs_n[k]) begin
                cs_rises[k]    <= cs_rises[k] + 1;
                cs_rise_cyc[k] <= cyc;
            end
            if (sclk[k] && !p_sclk[k]) begin
                rises[k]     <= rises[k] + 1;
                prev_rise[k] <= cyc;
                if (cs_n[k]) rise_nocs[k] <= rise_nocs[k] + 1;
                if (mon_bits[k] != 0 && (cyc - prev_rise[k]) != 2 * half_period(k))
                    bad_period[k] <= bad_period[k] + 1;
                if (mon_bits[k] == 0 && mon_words[k] < 8)
                    word_first_rise[k][mon_words[k]] <= cyc;
                if (mon_bits[k] == 31) begin
                    if (mon_words[k] < 8)
                        mon_word[k][mon_words[k]] <= {mon_shift[k][30:0], mosi[k]};
                    mon_words[k] <= mon_words[k] + 1;
                    mon_bits[k]  <= 0;
                end else begin
                    mon_shift[k] <= {mon_shift[k][30:0], mosi[k]};
                    mon_bits[k]  <= mon_bits[k] + 1;
                end
            end
            if (!sclk[k] && p_sclk[k]) sclk_fall_cyc[k] <= cyc;
            if (mosi[k] != p_mosi[k] && sclk[k]) mosi_bad[k] <= mosi_bad[k] + 1;
            if (!busy[k] && p_busy[k]) busy_fall_cyc[k] <= cyc;
            if (rx_valid[k]) rx_pulses[k] <= rx_pulses[k] + 1;
        end
        p_sclk <= sclk;
        p_cs_n <= cs_n;
        p_mosi <= mosi;
        p_busy <= busy;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input int k, input logic [31:0] w, input logic l, output int t);
        bit ok = 1'b0;
        data[k]  = w;
        last[k]  = l;
        valid[k] = 1'b1;
        for (int i = 0; i < 2000 && !ok; i++) begin
            if (ready[k]) ok = 1'b1;
            tick();
        end
        valid[k] = 1'b0;
        last[k]  = 1'b0;
        t = cyc;
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input int k);
        for (int i = 0; i < 1000 && busy[k]; i++) tick();
        if (busy[k]) check("done_timeout", 32'(busy[k]), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t, t2, p0, stall_bad;

        rst   = 1'b1;
        valid = '0;
        last  = '0;
        data[0] = '0;
        data[1] = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_cs_n",  32'(cs_n),     32'h3);
        check("rst_sclk",  32'(sclk),     32'h0);
        check("rst_mosi",  32'(mosi),     32'h0);
        check("rst_ready", 32'(ready),    32'h3);
        check("rst_rxv",   32'(rx_valid), 32'h0);
        check("rst_busy",  32'(busy),     32'h0);
        check("rst_rxd0",  rx_data[0],    32'h0);

        // Single word, CLK_DIV=2
        p0 = rx_pulses[0];
        send(0, 32'hA5C3_0F81, 1'b1, t);
        check("sw_cs_low",   32'(cs_n[0]), 32'd0);
        wait_done(0);
        check("sw_word",     mon_word[0][0],                  32'hA5C3_0F81);
        check("sw_rises",    32'(rises[0]),                   32'd32);
        check("sw_first",    32'(word_first_rise[0][0] - t),  32'd2);
        check("sw_period",   32'(bad_period[0]),              32'd0);
        check("sw_fall",     32'(sclk_fall_cyc[0] - t),       32'd128);
        check("sw_cs_rise",  32'(cs_rise_cyc[0] - t),         32'd130);
        check("sw_busy_off", 32'(busy_fall_cyc[0] - t),       32'd132);
        check("sw_pulses",   32'(rx_pulses[0] - p0),          32'd1);
        check("sw_rx",       rx_data[0],                      32'hA5C3_0F81);

        // Loopback
        p0 = rx_pulses[0];
        send(0, 32'hDEAD_BEEF, 1'b1, t);
        wait_done(0);
        check("lb_pulses", 32'(rx_pulses[0] - p0), 32'd1);
        check("lb_rx",     rx_data[0],             32'hDEAD_BEEF);

        // Three-word frame, valid held high
        p0 = cs_rises[0];
        send(0, 32'h0000_0001, 1'b0, t);
        send(0, 32'h8000_0000, 1'b0, t2);
        send(0, 32'hFFFF_FFFF, 1'b1, t2);
        wait_done(0);
        check("fr_rises",   32'(rises[0]),    32'd96);
        check("fr_words",   32'(mon_words[0]), 32'd3);
        check("fr_w0",      mon_word[0][0],   32'h0000_0001);
        check("fr_w1",      mon_word[0][1],   32'h8000_0000);
        check("fr_w2",      mon_word[0][2],   32'hFFFF_FFFF);
        check("fr_first",   32'(word_first_rise[0][0] - t), 32'd2);
        check("fr_space01", 32'(word_first_rise[0][1] - word_first_rise[0][0]), 32'd129);
        check("fr_space12", 32'(word_first_rise[0][2] - word_first_rise[0][1]), 32'd129);
        check("fr_cs_rise", 32'(cs_rises[0] - p0), 32'd1);
        check("fr_rx",      rx_data[0],       32'hFFFF_FFFF);

        // Stall inside a frame
        p0 = rx_pulses[0];
        send(0, 32'h1357_9BDF, 1'b0, t);
        for (int i = 0; i < 300 && rx_pulses[0] == p0; i++) tick();
        stall_bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (sclk[0] || cs_n[0] || !ready[0]) stall_bad++;
            tick();
        end
        check("st_idle_bus", 32'(stall_bad),            32'd0);
        check("st_pulses",   32'(rx_pulses[0] - p0),    32'd1);
        check("st_rx",       rx_data[0],                32'h1357_9BDF);
        send(0, 32'h2468_ACE0, 1'b1, t2);
        wait_done(0);
        check("st_words",  32'(mon_words[0]),                 32'd2);
        check("st_w1",     mon_word[0][1],                    32'h2468_ACE0);
        check("st_setup",  32'(word_first_rise[0][1] - t2),   32'd2);
        check("st_pulses2", 32'(rx_pulses[0] - p0),           32'd2);

        // Reset mid-word after the 10th rise
        send(0, 32'h0F0F_F0F0, 1'b1, t);
        for (int i = 0; i < 200 && rises[0] < 10; i++) tick();
        check("mr_reached", 32'(rises[0]), 32'd10);
        p0  = rx_pulses[0];
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_cs_n",  32'(cs_n[0]),     32'd1);
        check("mr_sclk",  32'(sclk[0]),     32'd0);
        check("mr_mosi",  32'(mosi[0]),     32'd0);
        check("mr_ready", 32'(ready[0]),    32'd1);
        check("mr_busy",  32'(busy[0]),     32'd0);
        check("mr_rxd",   rx_data[0],       32'h0);
        repeat (80) tick();
        check("mr_no_pulse", 32'(rx_pulses[0] - p0), 32'd0);
        send(0, 32'hC001_D00D, 1'b1, t);
        wait_done(0);
        check("mr_word", mon_word[0][0], 32'hC001_D00D);
        check("mr_rx",   rx_data[0],     32'hC001_D00D);

        // CLK_DIV=1, miso inverted
        send(1, 32'h1234_5678, 1'b1, t);
        wait_done(1);
        check("d1_word",    mon_word[1][0],                 32'h1234_5678);
        check("d1_rises",   32'(rises[1]),                  32'd32);
        check("d1_first",   32'(word_first_rise[1][0] - t), 32'd1);
        check("d1_period",  32'(bad_period[1]),             32'd0);
        check("d1_cs_rise", 32'(cs_rise_cyc[1] - sclk_fall_cyc[1]), 32'd1);
        check("d1_fall",    32'(sclk_fall_cyc[1] - t),      32'd64);
        check("d1_rx",      rx_data[1],                     32'hEDCB_A987);

        // Bus rules over the whole run
        check("mosi_stable0", 32'(mosi_bad[0]),  32'd0);
        check("mosi_stable1", 32'(mosi_bad[1]),  32'd0);
        check("rise_in_cs0",  32'(rise_nocs[0]), 32'd0);
        check("rise_in_cs1",  32'(rise_nocs[1]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fabric_spi_transmitter.md
Name: fabric_spi_transmitter

Overview:
- SPI host (mode 0: CPOL=0, CPHA=0; MSB first) that serialises 32-bit bitstream words onto sclk/cs_n/mosi.
- Drives the fabric SPI bitstream receiver from a second chip or test harness, and serves as the loopback driver in fabric-config benches.
- Words arrive on a valid/ready stream with a frame-end flag. cs_n stays low across all words of a frame.
- MISO is shifted in concurrently, and each received word is presented with a one-cycle valid pulse.

Parameters:
- CLK_DIV, 2, SCLK half-period in clk_i cycles (≥1); SCLK period = 2*CLK_DIV.
- WORD_WIDTH, 32, bits per word.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  reset, synchronous, active-high
- bitstream_data_i  input  WORD_WIDTH  word to transmit
- bitstream_last_i  input  1  word is last of frame; cs_n released after it
- bitstream_valid_i  input  1  word available
- bitstream_ready_o  output  1  transmitter accepts word this cycle (transfer = valid & ready)
- rx_data_o  output  WORD_WIDTH  word captured from miso_i
- rx_valid_o  output  1  one-cycle pulse, rx_data_o valid
- busy_o  output  1  high whenever state ≠ IDLE
- sclk_o  output  1  SPI clock, idles low
- cs_no  output  1  chip select, active low
- mosi_o  output  1  serial data out
- miso_i  input  1  serial data in

Behaviour:
- Design uses one clock. Reset is synchronous and active-high: all state is cleared on a rising clk_i edge with rst_i=1.
- Reset values: sclk_o=0, cs_no=1, mosi_o=0, bitstream_ready_o=1, rx_valid_o=0, rx_data_o=0, busy_o=0, state=IDLE.
- All outputs are registered. A divider counter counts 0..CLK_DIV-1.
- IDLE:
  - ready=1.
  - On transfer: load shift register, latch last flag, cs_no←0, mosi_o←data[MSB], go to SETUP.
- SETUP:
  - sclk low for CLK_DIV cycles with mosi stable.
  - Then sclk_o←1, go to SHIFT.
- SHIFT:
  - sclk_o toggles every CLK_DIV cycles.
  - On each rising edge, the cycle sclk_o is set to 1: capture miso_i into rx shift register LSB, shifting left.
  - On each falling edge except the last: mosi_o←next bit.
  - After the WORD_WIDTH-th high phase, sclk_o←0 and go to WORD_END.
  - Total: WORD_WIDTH high phases and WORD_WIDTH-1 interior low phases.
- WORD_END:
  - First cycle: rx_valid_o=1 and rx_data_o updates. rx_data_o holds until the next word completes.
  - If latched last=1: ready=0, go to HOLD.
  - If last=0: ready=1, cs_no stays 0. On transfer, load the new word, mosi_o←MSB, go to SETUP.
  - If last=0 and no valid: stall in WORD_END indefinitely with cs low and sclk low; no further rx_valid pulse.
- HOLD: cs low, sclk low for CLK_DIV cycles, then cs_no←1, go to GAP.
- GAP: cs high for CLK_DIV cycles, then go to IDLE. ready=0 throughout.
- ready is 0 in SETUP, SHIFT, HOLD and GAP. Valid asserted then is held off; no data is lost and no buffering is performed.
- Timing:
  - First rising sclk edge occurs CLK_DIV cycles after cs_no falls.
  - Back-to-back words within a frame (valid held high): one word per 64*CLK_DIV+1 cycles, measured cs_no-fall-equivalent to next SETUP start.
  - mosi_o changes only while sclk_o=0, or together with sclk_o falling.
- Width rules: bit counter is $clog2(WORD_WIDTH+1) bits. No wrap occurs, because the counter resets on each load.
- Reset mid-word:
  - The partial word is dropped.
  - cs_no=1 and sclk_o=0 on the next edge. rx_valid_o is not pulsed.
  - No guaranteed GAP time is provided after reset.
- bitstream_last_i is sampled only on transfer. Changes at other times are ignored.

Test Plan:
- Single word, CLK_DIV=2: send 0xA5C3_0F81 with last=1 → cs_no low 1 cycle after transfer; 32 sclk rising edges at 4-cycle period; mosi sampled at rises = 1010_0101_1100_0011_0000_1111_1000_0001; cs_no rises 2 cycles after final fall; busy_o returns to 0 2 cycles later.
- Loopback, miso_i tied to mosi_o: send 0xDEAD_BEEF → rx_valid_o pulses once, rx_data_o=0xDEAD_BEEF.
- Three-word frame, valid always high, last on word 3: send 0x0000_0001, 0x8000_0000, 0xFFFF_FFFF → cs_no low continuously through all 96 rises, words spaced exactly 129 cycles, single cs_no rise at end; then feed into fabric_spi_receiver model → same three words on its bitstream_data_o.
- Stall: word 1 last=0, valid dropped 50 cycles → cs_no stays low, sclk_o stays 0, ready_o=1, exactly one rx_valid pulse; word 2 resumes with SETUP.
- Reset mid-word: assert rst_i for 1 cycle after 10th sclk rise → next edge cs_no=1, sclk_o=0, mosi_o=0, ready_o=1, no rx_valid; next word transmits correctly from MSB.
- CLK_DIV=1: send 0x1234_5678 last=1 → sclk period 2 cycles, 32 rises, correct bits, cs_no high 1 cycle after final fall.
